// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor: operands and start in,
// status and registered result out.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             b_out;

   modport master (
      output start, a, b, b_in,
      input  busy, done, diff, b_out
   );

   modport slave (
      input  start, a, b, b_in,
      output busy, done, diff, b_out
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - b_in computed LSB-first, one
// full-subtractor step per clock, with a registered borrow between steps.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             last;
   logic             busy;
   logic             done;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic             br;
   logic             br_next;
   logic             d;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] diff_q;
   logic             b_out_q;

   // One full-subtractor cell; returns {borrow_out, difference}.
   function automatic logic [1:0] sub_step(input logic a0, input logic b0, input logic bi);
      logic dd;
      logic bo;
      dd = a0 ^ b0 ^ bi;
      bo = (~a0 & b0) | (~(a0 ^ b0) & bi);
      return {bo, dd};
   endfunction

   always_comb begin
      {br_next, d} = sub_step(a_sh[0], b_sh[0], br);
      res_next = res_sh >> 1;
      res_next[WIDTH-1] = d;
      last = (count == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (bus.start) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Result registers update only on the final step, so partial sums never leak.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         br      <= 1'b0;
         count   <= '0;
         diff_q  <= '0;
         b_out_q <= 1'b0;
      end else if (accept) begin
         a_sh  <= bus.a;
         b_sh  <= bus.b;
         br    <= bus.b_in;
         count <= '0;
      end else if (state == SHIFT) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         res_sh <= res_next;
         br     <= br_next;
         count  <= count + 1'b1;
         if (last) begin
            diff_q  <= res_next;
            b_out_q <= br_next;
         end
      end
   end

   assign bus.busy  = busy;
   assign bus.done  = done;
   assign bus.diff  = diff_q;
   assign bus.b_out = b_out_q;
endmodule
